bitcoin_nonce_search: RTL and testbench

// - Parametrised multi-core Bitcoin nonce sweeper: reads 20-word header once, computes block-1 midstate once.
// - Sweeps [nonce_start, nonce_start+nonce_count) in batches of NUM_CORES: second block + second SHA-256 per nonce.
// - Writes final H0 per nonce and reports the first nonce whose H0 meets a leading-zero target.
// - Sits behind the shared single-port word memory.

---
 rtl/bitcoin_nonce_search.sv | 254 +++++++++++++++++++++++++
 tb/tb_bitcoin_nonce_search.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_nonce_search.sv
// Multi-core double-SHA-256 nonce sweeper behind a shared single-port word memory.
// Optional BTC_NONCE_EARLY_EXIT_EN: finish after the batch in which the first qualifying nonce is found.

module sha256_lane (
    input  logic              clk,
    input  logic              load,
    input  logic              step,
    input  logic [31:0]       k_t,
    input  logic [7:0][31:0]  init_h,
    input  logic [15:0][31:0] init_w,
    output logic [7:0][31:0]  dig
);
    logic [7:0][31:0]  st, hh;
    logic [15:0][31:0] w;
    logic [31:0]       t1, t2, w_nx;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        t1 = st[7] + (rotr(st[4], 6) ^ rotr(st[4], 11) ^ rotr(st[4], 25))
           + ((st[4] & st[5]) ^ (~st[4] & st[6])) + k_t + w[0];
        t2 = (rotr(st[0], 2) ^ rotr(st[0], 13) ^ rotr(st[0], 22))
           + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
        // w[0] is W[t]; the window slides by one and W[t+16] enters at the top
        w_nx = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
             + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        for (int i = 0; i < 8; i++) dig[i] = hh[i] + st[i];
    end

    always_ff @(posedge clk) begin
        if (load) begin
            st <= init_h;
            hh <= init_h;
            w  <= init_w;
        end else if (step) begin
            st <= {st[6:4], st[3] + t1, st[2:0], t1 + t2};
            w  <= {w_nx, w[15:1]};
        end
    end
endmodule

module bitcoin_nonce_search #(
    parameter int NUM_CORES = 16,
    parameter int NONCE_W   = 32,
    parameter int ADDR_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  message_addr,
    input  logic [ADDR_W-1:0]  output_addr,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_count,
    input  logic [5:0]         target_zeros,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               mem_clk,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data
);
    localparam int LW = $clog2(NUM_CORES + 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [3:0] {IDLE, READ, MID, LOAD, BLK2, HASH2, CHECK, WRITE, DONE} state_t;

    state_t                          state;
    logic [6:0]                      cnt;
    logic [LW-1:0]                   wi;
    logic [ADDR_W-1:0]               msg_l, out_l;
    logic [NONCE_W-1:0]              count_l, offset, batch_base, hit_off;
    logic [5:0]                      tz_l;
    logic [18:0][31:0]               hdr;
    logic [7:0][31:0]                mid_h, lane_h;
    logic [NUM_CORES-1:0]            lane_valid, hits;
    logic [NUM_CORES-1:0][31:0]      h0_r;
    logic [NUM_CORES-1:0][7:0][31:0] dig;
    logic                            core_load, core_step, wr_valid, more, stop_early;
    logic [31:0]                     wr_data, zmask;

    assign mem_clk = clk;

`ifdef BTC_NONCE_EARLY_EXIT_EN
    assign stop_early = found;
`else
    assign stop_early = 1'b0;
`endif

    assign core_load = (state == READ && cnt == 7'd20) || state == LOAD || (state == BLK2 && cnt == 7'd64);
    assign core_step = (state == MID || state == BLK2 || state == HASH2) && !cnt[6];
    assign lane_h    = (state == LOAD) ? mid_h : IV;
    assign more      = ({1'b0, offset} + (NONCE_W+1)'(NUM_CORES)) < {1'b0, count_l};

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
        logic [NONCE_W-1:0] lane_nonce;
        logic [15:0][31:0]  blk_w;

        assign lane_nonce = batch_base + NONCE_W'(g);

        always_comb begin
            blk_w = '0;
            if (state == LOAD) begin
                blk_w[2:0] = hdr[18:16];
                blk_w[3]   = 32'(lane_nonce);
                blk_w[4]   = 32'h8000_0000;
                blk_w[15]  = 32'd640;
            end else if (state == BLK2) begin
                blk_w[7:0] = dig[g];
                blk_w[8]   = 32'h8000_0000;
                blk_w[15]  = 32'd256;
            end else begin
                blk_w = hdr[15:0];
            end
        end

        sha256_lane u_lane (
            .clk    (clk),
            .load   (core_load),
            .step   (core_step),
            .k_t    (K[cnt[5:0]]),
            .init_h (lane_h),
            .init_w (blk_w),
            .dig    (dig[g])
        );
    end

    // tz_l is already clamped to 32; a shift of 32 yields an all-ones mask
    always_comb begin
        zmask   = ~(32'hFFFF_FFFF >> tz_l);
        hit_off = '0;
        for (int i = 0; i < NUM_CORES; i++)
            hits[i] = lane_valid[i] && ((h0_r[i] & zmask) == 32'd0);
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (hits[i]) hit_off = NONCE_W'(i);
        wr_valid = 1'b0;
        wr_data  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (wi == LW'(i)) begin
                wr_valid = lane_valid[i];
                wr_data  = h0_r[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            done           <= 1'b0;
            found          <= 1'b0;
            found_nonce    <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            cnt            <= '0;
            wi             <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    msg_l       <= message_addr;
                    out_l       <= output_addr;
                    count_l     <= nonce_count;
                    tz_l        <= (target_zeros > 6'd32) ? 6'd32 : target_zeros;
                    offset      <= '0;
                    batch_base  <= nonce_start;
                    found       <= 1'b0;
                    found_nonce <= '0;
                    cnt         <= '0;
                    if (nonce_count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= READ;
                        mem_addr <= message_addr;
                    end
                end
                // data for the address shown in cycle c is captured in cycle c+1
                READ: begin
                    for (int j = 0; j < 19; j++)
                        if (cnt == 7'(j + 1)) hdr[j] <= mem_read_data;
                    if (cnt < 7'd19) mem_addr <= msg_l + ADDR_W'(cnt + 7'd1);
                    if (cnt == 7'd20) begin
                        cnt   <= '0;
                        state <= MID;
                    end else cnt <= cnt + 7'd1;
                end
                MID: if (cnt == 7'd64) begin
                    mid_h <= dig[0];
                    cnt   <= '0;
                    state <= LOAD;
                end else cnt <= cnt + 7'd1;
                LOAD: begin
                    for (int i = 0; i < NUM_CORES; i++)
                        lane_valid[i] <= ({1'b0, offset} + (NONCE_W+1)'(i)) < {1'b0, count_l};
                    cnt   <= '0;
                    state <= BLK2;
                end
                BLK2: if (cnt == 7'd64) begin
                    cnt   <= '0;
                    state <= HASH2;
                end else cnt <= cnt + 7'd1;
                HASH2: if (cnt == 7'd64) begin
                    for (int i = 0; i < NUM_CORES; i++) h0_r[i] <= dig[i][0];
                    cnt   <= '0;
                    state <= CHECK;
                end else cnt <= cnt + 7'd1;
                CHECK: begin
                    if (!found && |hits) begin
                        found       <= 1'b1;
                        found_nonce <= batch_base + hit_off;
                    end
                    wi    <= '0;
                    state <= WRITE;
                end
                // valid lanes are always a contiguous run from lane 0
                WRITE: if (wr_valid) begin
                    mem_we         <= 1'b1;
                    mem_addr       <= out_l + ADDR_W'(offset) + ADDR_W'(wi);
                    mem_write_data <= wr_data;
                    wi             <= wi + LW'(1);
                end else begin
                    mem_we     <= 1'b0;
                    offset     <= offset + NONCE_W'(NUM_CORES);
                    batch_base <= batch_base + NONCE_W'(NUM_CORES);
                    if (more && !stop_early) state <= LOAD;
                    else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// Scoreboard bench for bitcoin_nonce_search: a reference double-SHA-256 model predicts every H0 write.
module tb_bitcoin_nonce_search;
    localparam logic [15:0] MSG = 16'h0100;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [7:0][31:0] IVT = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset, start, done, found, mem_clk, mem_we;
    logic [15:0] message_addr, output_addr, mem_addr;
    logic [31:0] nonce_start, nonce_count, found_nonce, mem_write_data, mem_read_data;
    logic [5:0]  target_zeros;

    logic [31:0]      mem [0:65535];
    logic [31:0]      hdrw [20];
    logic [7:0][31:0] mid;
    wr_t              sb [$];
    int               n_cmp = 0, n_bad = 0, nwr = 0;

    bitcoin_nonce_search dut (
        .clk(clk), .reset(reset), .start(start), .message_addr(message_addr),
        .output_addr(output_addr), .nonce_start(nonce_start), .nonce_count(nonce_count),
        .target_zeros(target_zeros), .done(done), .found(found), .found_nonce(found_nonce),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge mem_clk) begin
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] blk);
        logic [31:0] w [64];
        logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2;
        logic [7:0][31:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {vh, vg, vf, ve, vd, vc, vb, va} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = vh + (rr(ve, 6) ^ rr(ve, 11) ^ rr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + KT[t] + w[t];
            t2 = (rr(va, 2) ^ rr(va, 13) ^ rr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
            vh = vg; vg = vf; vf = ve; ve = vd + t1;
            vd = vc; vc = vb; vb = va; va = t1 + t2;
        end
        r = {vh, vg, vf, ve, vd, vc, vb, va};
        for (int i = 0; i < 8; i++) r[i] = r[i] + hin[i];
        return r;
    endfunction

    function automatic logic [31:0] h0_of(input logic [31:0] nonce);
        logic [15:0][31:0] b;
        logic [7:0][31:0]  d, f;
        b = '0;
        b[0] = hdrw[16]; b[1] = hdrw[17]; b[2] = hdrw[18]; b[3] = nonce;
        b[4] = 32'h8000_0000; b[15] = 32'd640;
        d = compress(mid, b);
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = d[i];
        b[8] = 32'h8000_0000; b[15] = 32'd256;
        f = compress(IVT, b);
        return f[0];
    endfunction

    function automatic int clz(input logic [31:0] x);
        for (int i = 31; i >= 0; i--) if (x[i]) return 31 - i;
        return 32;
    endfunction

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            wr_t e;
            nwr++;
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_write_data), 64'(e.data));
            end
        end
    end

    task automatic run_job(input string tag, input logic [31:0] ns, input logic [31:0] nc,
                           input logic [5:0] tz, input logic [15:0] oa, input int nexp, output int cyc);
        logic        ef;
        logic [31:0] efn, hv;
        int          tzc, budget;
        wr_t         e;
        ef = 1'b0; efn = '0;
        tzc = (tz > 6'd32) ? 32 : int'(tz);
        for (int k = 0; k < int'(nc); k++) begin
            hv = h0_of(ns + 32'(k));
            if (k < nexp) begin
                e.addr = oa + 16'(k);
                e.data = hv;
                sb.push_back(e);
            end
            if (!ef && clz(hv) >= tzc) begin
                ef = 1'b1;
                efn = ns + 32'(k);
            end
        end
        nwr = 0;
        budget = 300 * (int'(nc) / 16 + 1) + 200;
        @(negedge clk);
        message_addr = MSG; output_addr = oa; nonce_start = ns;
        nonce_count = nc; target_zeros = tz; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_found"}, 64'(found), 64'(ef));
        if (ef) chk({tag, "_found_nonce"}, 64'(found_nonce), 64'(efn));
        chk({tag, "_n_writes"}, 64'(nwr), 64'(nexp));
        chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0][31:0] abc;
        logic [7:0][31:0]  habc;
        int                clzs [2048];
        int                cyc, gs, gm, nexp_gold;
        bit                ok;

        reset = 1'b1; start = 1'b0;
        message_addr = '0; output_addr = '0; nonce_start = '0; nonce_count = '0; target_zeros = '0;
        for (int j = 0; j < 20; j++) begin
            hdrw[j] = (32'h9e3779b9 * 32'(j + 1)) ^ 32'h0123_4567;
            mem[MSG + 16'(j)] = hdrw[j];
        end
        abc = '0;
        for (int j = 0; j < 16; j++) abc[j] = hdrw[j];
        mid = compress(IVT, abc);

        abc = '0; abc[0] = 32'h6162_6380; abc[15] = 32'h18;
        habc = compress(IVT, abc);
        chk("model_abc", 64'(habc[0]), 64'hba7816bf);

        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_found_nonce", 64'(found_nonce), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wd", 64'(mem_write_data), 64'd0);
        reset = 1'b0;

        run_job("all16", 32'd0, 32'd16, 6'd0, 16'h1000, 16, cyc);
        chk("all16_fn0", 64'(found_nonce), 64'd0);

        run_job("zero", 32'd5, 32'd0, 6'd0, 16'h1000, 0, cyc);
        chk("zero_latency_ok", 64'(cyc <= 2), 64'd1);

        run_job("part", 32'h55, 32'd20, 6'd32, 16'h2000, 20, cyc);
        run_job("wrap", 32'hFFFF_FFF8, 32'd16, 6'd1, 16'h3000, 16, cyc);

        // pick a window whose single deepest-zero H0 sits at offset 37
        for (int n = 0; n < 2048; n++) clzs[n] = clz(h0_of(32'h1000_0000 + 32'(n)));
        gs = -1; gm = 0;
        for (int s = 0; s <= 2048 - 64 && gs < 0; s++) begin
            ok = 1'b1;
            for (int j = 0; j < 64; j++)
                if (j != 37 && clzs[s + j] >= clzs[s + 37]) ok = 1'b0;
            if (ok) begin
                gs = s;
                gm = clzs[s + 37];
            end
        end
        chk("gold_window", 64'(gs >= 0), 64'd1);
        if (gs >= 0) begin
`ifdef BTC_NONCE_EARLY_EXIT_EN
            nexp_gold = 48;
`else
            nexp_gold = 64;
`endif
            run_job("gold", 32'h1000_0000 + 32'(gs), 32'd64, 6'(gm), 16'h4000, nexp_gold, cyc);
            chk("gold_fn37", 64'(found_nonce), 64'(32'h1000_0000 + 32'(gs) + 32'd37));
        end

        @(negedge clk);
        message_addr = MSG; output_addr = 16'h5000; nonce_start = 32'd100;
        nonce_count = 32'd32; target_zeros = 6'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (180) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_found", 64'(found), 64'd0);
        sb.delete();
        run_job("post", 32'h77, 32'd4, 6'd0, 16'h5000, 4, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
